// File: rtl/oclib_pkg.sv
// oclib_pkg: shared constants and helpers for the oclib ready/valid blocks
package oclib_pkg;
  localparam bit True = 1'b1;
  localparam bit False = 1'b0;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/oclib_ready_valid_stage.sv
// oclib_ready_valid_stage: one 2-entry retime stage (head + skid) with flop-driven data and ready
module oclib_ready_valid_stage import oclib_pkg::*; #(
  parameter int Width = 1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             flush,
  input  logic [Width-1:0] upData,
  input  logic             upValid,
  output logic             upReady,
  output logic [Width-1:0] dnData,
  output logic             dnValid,
  input  logic             dnReady,
  output logic [1:0]       occNext
);
  logic [1:0] occ_q, occ_d;
  logic ready_q, ready_d;
  logic [Width-1:0] head_q, head_d, skid_q, skid_d;
  logic push, pop;
  assign upReady = ready_q && !flush;
  assign dnValid = occ_q != 2'd0;
  assign dnData = head_q;
  assign occNext = occ_d;
  // push and pop together only happen at occupancy 1, where the head is replaced
  always_comb begin
    push = upValid && upReady;
    pop = dnValid && dnReady;
    occ_d = flush ? 2'd0 : occ_q + {1'b0, push} - {1'b0, pop};
    ready_d = occ_d != 2'd2;
    head_d = (push && (occ_q == 2'd0 || pop)) ? upData : (pop && occ_q == 2'd2) ? skid_q : head_q;
    skid_d = (push && !pop && occ_q == 2'd1) ? upData : skid_q;
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      occ_q <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ready_q <= ready_d;
    end
  end
  always_ff @(posedge clock) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end
endmodule

// File: rtl/oclib_ready_valid_pipeline.sv
// oclib_ready_valid_pipeline: cascade of Stages skid-buffered retime stages; Stages=0 is a wire
module oclib_ready_valid_pipeline import oclib_pkg::*; #(
  parameter int Width = 1,
  parameter int Stages = 1,
  parameter int CountWidth = clog2_min1(2 * Stages + 1)
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  flush,
  input  logic [Width-1:0]      inData,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [Width-1:0]      outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [CountWidth-1:0] count
);
  logic [Width-1:0] dat [Stages+1];
  logic vld [Stages+1];
  logic rdy [Stages+1];
  logic [CountWidth-1:0] sum [Stages+1];
  logic [CountWidth-1:0] count_q, count_d;
  assign dat[0] = inData;
  assign vld[0] = inValid;
  assign rdy[Stages] = outReady;
  assign sum[0] = '0;
  assign inReady = rdy[0];
  assign outData = dat[Stages];
  assign outValid = vld[Stages];
  assign count = count_q;
  for (genvar g = 0; g < Stages; g++) begin : g_stage
    logic [1:0] occ_n;
    oclib_ready_valid_stage #(.Width(Width)) u_stage (
      .clock(clock), .resetN(resetN), .flush(flush),
      .upData(dat[g]), .upValid(vld[g]), .upReady(rdy[g]),
      .dnData(dat[g+1]), .dnValid(vld[g+1]), .dnReady(rdy[g+1]),
      .occNext(occ_n)
    );
    assign sum[g+1] = sum[g] + CountWidth'(occ_n);
  end
  // registering the next-state sum keeps count equal to the beats held after each edge
  always_comb count_d = sum[Stages];
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) count_q <= '0;
    else count_q <= count_d;
  end
endmodule

// File: doc/oclib_ready_valid_pipeline.md
OCLIB_READY_VALID_PIPELINE -- requirements
Module: oclib_ready_valid_pipeline

Interface
REQ-001 SHALL have parameter Width, default 1: data bits per beat, legal 1..1024.
REQ-002 SHALL have parameter Stages, default 1: number of cascaded retime stages, legal 0..8; 0 = combinational passthrough.
REQ-003 SHALL have parameter CountWidth, default $clog2(2*Stages+1) (minimum 1): width of occupancy output.
REQ-004 clock  input  1  sole clock; all state on rising edge.
REQ-005 resetN  input  1  asynchronous, active-low reset; assertion acts immediately, deassertion sampled on clock.
REQ-006 flush  input  1  synchronous clear of all held beats.
REQ-007 inData  input  Width  upstream beat.
REQ-008 inValid  input  1  upstream beat valid.
REQ-009 inReady  output  1  pipeline accepts beat this cycle.
REQ-010 outData  output  Width  downstream beat.
REQ-011 outValid  output  1  downstream beat valid.
REQ-012 outReady  input  1  downstream accepts.
REQ-013 count  output  CountWidth  total beats held across all stages.

Function
REQ-014 Each stage SHALL hold 0, 1 or 2 beats in FIFO order (head slot plus skid slot).
REQ-015 Per stage: push = upValid && upReady; pop = dnValid && dnReady; occupancy next = occ + push - pop.
REQ-016 Stage dnValid SHALL equal (occ != 0); stage dnData SHALL be the head slot, driven directly from a flop.
REQ-017 Stage upReady SHALL be driven directly from a flop, equal to (occ < 2) after the update, with no combinational path from dnReady.
REQ-018 Simultaneous push and pop at occ=2 SHALL NOT occur (upReady=0); at occ=1 occupancy stays 1, head replaced by the incoming beat; at occ=0 push alone gives occ=1.
REQ-019 Stages SHALL chain: stage k dn* connects to stage k+1 up*; stage 0 up* = in*; last stage dn* = out*.
REQ-020 Latency: a beat accepted at edge N into an empty pipeline SHALL appear on outValid/outData after edge N+Stages-1, i.e. visible in cycle N+Stages.
REQ-021 Throughput: with outReady held 1 and inValid held 1, one beat SHALL transfer per cycle indefinitely with no bubbles.
REQ-022 Beats SHALL never be dropped, duplicated or reordered; outData SHALL be stable while outValid && !outReady.
REQ-023 count SHALL equal the sum of stage occupancies, registered, max 2*Stages.
REQ-024 flush=1 SHALL, at the next edge, set all occupancies to 0 regardless of push/pop that cycle; inReady SHALL be 0 during the flush cycle; beats presented during flush are not accepted.
REQ-025 Stages=0: outData=inData, outValid=inValid, inReady=outReady, count=0; flush ignored.

Reset
REQ-026 While resetN=0: all occupancies 0, outValid=0, inReady=0, count=0.
REQ-027 inReady SHALL rise at the first clock edge after resetN deasserts.
REQ-028 Data slots SHALL NOT be reset.
REQ-029 Reset assertion mid-transfer SHALL discard all held beats; no partial beat emerges after release.

Structure
REQ-030 One sub-module oclib_ready_valid_stage (Width parameter, one 2-entry stage with clock/resetN/flush), instantiated Stages times via generate.
REQ-031 No new package typedefs; boolean parameters use oclib_pkg True/False.
REQ-032 No resynchronisation of resetN inside the block.

Verification
REQ-033 Stages=3, Width=8, outReady=1, push 0x01..0x10 back-to-back -> first beat out 3 cycles after acceptance, 16 consecutive beats in order, count peaks at 3.
REQ-034 Stages=2, outReady=0, inValid=1 -> accepts exactly 4 beats, inReady=0, count=4; raise outReady -> 4 beats out in order, then through-flow resumes with no loss.
REQ-035 Stages=1, random inValid/outReady at 50% each for 10000 cycles -> scoreboard match, outData stable under backpressure, inReady and outData proven flop-driven.
REQ-036 Stages=2, hold 3 beats, pulse flush with inValid=1 -> count=0 and outValid=0 next cycle, flushed-cycle beat absent downstream.
REQ-037 Assert resetN=0 mid-stream with 4 beats held -> outValid, inReady, count 0 immediately; after release inReady=1 next edge, no stale beat emitted.
REQ-038 Stages=0 -> outputs track inputs combinationally in the same cycle, count=0.
